sw2led_ctrl: RTL and testbench

- Parametrised successor to the fixed 8-bit switch-to-LED path.
- Per channel: synchronises each switch input, debounces it, then drives the LED in one of four run-time modes: direct, toggle, latch or blink.
- Produces one-cycle rise/fall event pulses per channel for downstream logic.
- Sits between the board switch pins and the LED pins on the single system clock.

---
 rtl/sw2led_ctrl.sv | 118 +++++++++++
 tb/tb_sw2led_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sw2led_ctrl.sv
// Switch-to-LED path: two-flop sync, debounce, rise/fall events, and four LED modes.
// Latency: sw_db at t+1+DEBOUNCE_CYCLES, ld one edge later; no backpressure.
module sw2led_ctrl #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BLINK_DIV       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] latch_clr,
  output logic [WIDTH-1:0] ld,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_TOGGLE = 2'd1,
    MODE_LATCH  = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  logic [WIDTH-1:0] s1, s2;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] st, st_nxt;
  logic [WIDTH-1:0] ld_nxt;
  logic [1:0]       mode_q;
  logic [PW-1:0]    pre;
  logic             phase;
  mode_e            mode_cur;

  assign mode_cur = mode_e'(mode);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= '0;
      s2    <= '0;
      sw_db <= '0;
      rise  <= '0;
      fall  <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      s1   <= sw;
      s2   <= s1;
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == sw_db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          cnt[i]   <= '0;
          sw_db[i] <= s2[i];
          rise[i]  <= s2[i];
          fall[i]  <= ~s2[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // A mode change wipes all channel state and swallows a rise on the same edge.
  always_comb begin
    st_nxt = st;
    if (mode != mode_q) begin
      st_nxt = '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (latch_clr[i])
          st_nxt[i] = 1'b0;
        else if (mode_cur == MODE_TOGGLE && rise[i])
          st_nxt[i] = ~st[i];
        else if (mode_cur == MODE_LATCH && rise[i])
          st_nxt[i] = 1'b1;
      end
    end
  end

  always_comb begin
    ld_nxt = sw_db;
    case (mode_cur)
      MODE_DIRECT: ld_nxt = sw_db;
      MODE_TOGGLE,
      MODE_LATCH:  ld_nxt = st;
      MODE_BLINK:  ld_nxt = sw_db & {WIDTH{phase}};
      default:     ld_nxt = sw_db;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= '0;
      mode_q <= '0;
      pre    <= '0;
      phase  <= 1'b0;
      ld     <= '0;
    end else begin
      st     <= st_nxt;
      mode_q <= mode;
      ld     <= ld_nxt;
      if (pre == PRE_LAST) begin
        pre   <= '0;
        phase <= ~phase;
      end else begin
        pre <= pre + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sw2led_ctrl.sv
// Directed bench for sw2led_ctrl with WIDTH=8, DEBOUNCE_CYCLES=4, BLINK_DIV=8.
module tb_sw2led_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] sw;
  logic [1:0] mode;
  logic [7:0] latch_clr;
  logic [7:0] ld, sw_db, rise, fall;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  sw2led_ctrl #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .BLINK_DIV(8)) dut (
    .clk(clk), .rst(rst), .sw(sw), .mode(mode), .latch_clr(latch_clr),
    .ld(ld), .sw_db(sw_db), .rise(rise), .fall(fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int   nr, nf, rise_cyc, ld_cyc;
    logic hi, seen, found, prev3;
    logic [7:0] prev, v, exp;

    rst = 1'b1; sw = 8'hFF; mode = 2'd0; latch_clr = 8'h00;
    step(3);
    check("rst_ld", ld, 8'h00);
    check("rst_sw_db", sw_db, 8'h00);
    check("rst_rise", rise, 8'h00);
    check("rst_fall", fall, 8'h00);

    // First sampling edge is the first step after release.
    rst = 1'b0; sw = 8'hA5;
    step(5);
    check("db_early", sw_db, 8'h00);
    step(1);
    check("db_on_time", sw_db, 8'hA5);
    check("rise_pulse", rise, 8'hA5);
    check("ld_lag", ld, 8'h00);
    step(1);
    check("ld_direct", ld, 8'hA5);
    check("rise_one_cycle", rise, 8'h00);

    // Glitch rejection on channel 0
    sw = 8'hA4;
    step(10);
    check("db_a4", sw_db, 8'hA4);
    sw[0] = 1'b1; step(3); sw[0] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step(1);
      seen |= rise[0] | sw_db[0] | ld[0];
    end
    check("glitch_reject", 8'(seen), 8'h00);

    nr = 0; nf = 0; hi = 1'b0;
    sw[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(1);
      nr += int'(rise[0]); nf += int'(fall[0]); hi |= sw_db[0];
    end
    sw[0] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step(1);
      nr += int'(rise[0]); nf += int'(fall[0]); hi |= sw_db[0];
    end
    check("pulse6_rise_cnt", 8'(nr), 8'd1);
    check("pulse6_fall_cnt", 8'(nf), 8'd1);
    check("pulse6_db_high", 8'(hi), 8'd1);

    // Toggle mode on channel 3: rise -> st next edge -> ld one edge later
    mode = 2'd1;
    step(2);
    prev3 = ld[3];
    for (int p = 0; p < 3; p++) begin
      rise_cyc = -100; ld_cyc = -200;
      for (int k = 0; k < 20; k++) begin
        sw[3] = (k < 10);
        step(1);
        if (rise[3]) rise_cyc = cyc;
        if (ld[3] !== prev3) begin ld_cyc = cyc; prev3 = ld[3]; end
      end
      check($sformatf("toggle_ld3_%0d", p), 8'(ld[3]), (p % 2 == 0) ? 8'd1 : 8'd0);
      check($sformatf("toggle_lat_%0d", p), 8'(ld_cyc - rise_cyc), 8'd2);
      check($sformatf("toggle_others_%0d", p), ld & 8'hF7, 8'h00);
    end

    // Latch mode on channel 5, then clear coincident with a rise
    mode = 2'd2;
    sw[5] = 1'b0; step(10);
    sw[5] = 1'b1; step(10);
    check("latch_set", 8'(ld[5]), 8'd1);
    sw[5] = 1'b0; step(10);
    check("latch_hold", 8'(ld[5]), 8'd1);
    sw[5] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      step(1);
      if (rise[5]) found = 1'b1;
    end
    check("latch_rise_seen", 8'(found), 8'd1);
    latch_clr[5] = 1'b1; step(1); latch_clr = 8'h00;
    step(1);
    check("clr_wins", 8'(ld[5]), 8'd0);
    step(5);
    check("clr_stays", 8'(ld[5]), 8'd0);

    sw[2] = 1'b0; step(10);
    sw[2] = 1'b1; step(10);
    check("latch_ch2", 8'(ld[2]), 8'd1);
    mode = 2'd1;
    step(3);
    check("mode_chg_clr", 8'(ld[2]), 8'd0);
    check("mode_chg_all", ld, 8'h00);

    // Blink: phase half-period 8 cycles
    mode = 2'd3; sw = 8'h0F;
    step(12);
    check("blink_db", sw_db, 8'h0F);
    prev = ld; found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1);
      if (ld !== prev) found = 1'b1;
    end
    check("blink_edge_seen", 8'(found), 8'd1);
    v = ld;
    check("blink_upper", v & 8'hF0, 8'h00);
    for (int j = 1; j <= 24; j++) begin
      step(1);
      exp = (((j / 8) % 2) == 0) ? v : (v ^ 8'h0F);
      check($sformatf("blink_%0d", j), ld, exp);
    end

    // Reset two edges into a debounce count, then restart from zero
    mode = 2'd0;
    step(2);
    sw = 8'h8F;
    step(2);
    step(2);
    rst = 1'b1;
    step(2);
    check("midrst_db", sw_db, 8'h00);
    check("midrst_ld", ld, 8'h00);
    rst = 1'b0;
    nr = 0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      nr += int'(rise != 8'h00);
    end
    check("midrst_no_early_rise", 8'(nr), 8'd0);
    step(1);
    check("midrst_rise", rise, 8'h8F);
    check("midrst_sw_db", sw_db, 8'h8F);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
